// File: rtl/stream_pkg.sv
// Shared stream types: state encoding for the flushable upsizer.
package stream_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      OUTPUT  = 1'b1
   } upsizer_state_e;

endpackage

// File: rtl/stream_upsizer_flushable.sv
// Flushable stream upsizer: packs Ratio consecutive beats into one wide word
// with a per-slot strobe. last_i closes a word early; flush_i drops the
// partial word and any pending output word in the same cycle.
module stream_upsizer_flushable
   import stream_pkg::*;
#(
   parameter type         T     = logic,
   parameter int unsigned Ratio = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  logic [$bits(T)-1:0]       data_i,
   input  logic                      last_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [Ratio*$bits(T)-1:0] data_o,
   output logic [Ratio-1:0]          strb_o
);

   localparam int unsigned DataW = $bits(T);
   localparam int unsigned CntW  = $clog2(Ratio);

   upsizer_state_e                    r_state;
   logic [CntW-1:0]                   r_cnt;
   logic [Ratio-1:0]                  r_strb;
   logic [Ratio-1:0][DataW-1:0]       r_slot;

   upsizer_state_e                    w_state_next;
   logic [CntW-1:0]                   w_cnt_next;
   logic [Ratio-1:0]                  w_strb_next;
   logic                              w_ready;
   logic                              w_valid;
   logic                              w_hs_in;
   logic                              w_hs_out;
   logic                              w_close;

   // Handshakes and next state; flush suppresses both handshakes.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      w_ready      = 1'b0;
      w_valid      = 1'b0;
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_strb_next  = r_strb;

      unique case (r_state)
         COLLECT: w_ready = !flush_i;
         OUTPUT: begin
            w_valid = !flush_i;
            w_ready = ready_i && !flush_i;
         end
         default: ;
      endcase

      w_hs_in  = valid_i && w_ready;
      w_hs_out = w_valid && ready_i;
      w_close  = w_hs_in && ((r_cnt == CntW'(Ratio - 1)) || last_i);

      if (flush_i) begin
         w_state_next = COLLECT;
         w_cnt_next   = '0;
         w_strb_next  = '0;
      end else begin
         // Emitting the word frees all slots; a same-cycle beat then
         // re-arms its own strobe (r_cnt is 0 while in OUTPUT).
         if (w_hs_out) begin
            w_strb_next  = '0;
            w_state_next = COLLECT;
         end
         if (w_hs_in) begin
            w_strb_next[r_cnt] = 1'b1;
            if (w_close) begin
               w_cnt_next   = '0;
               w_state_next = OUTPUT;
            end else begin
               w_cnt_next = r_cnt + CntW'(1);
            end
         end
      end
   end

   // State, slot counter and strobe registers.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, independent of block order.
      if (!rst_ni) begin
         r_state <= COLLECT;
         r_cnt   <= '0;
         r_strb  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_strb  <= w_strb_next;
      end
   end

   // Slot data; flush leaves it stale because the strobe is authoritative.
   always_ff @(posedge clk_i) begin
      // NOTE: the data store is reset deliberately so data_o reads zero
      // after reset; flush alone does not clear it.
      if (!rst_ni) begin
         r_slot <= '0;
      end else if (w_hs_in) begin
         r_slot[r_cnt] <= data_i;
      end
   end

   assign ready_o = w_ready;
   assign valid_o = w_valid;
   assign data_o  = r_slot;
   assign strb_o  = r_strb;

endmodule

// File: tb/tb_stream_upsizer_flushable.sv
// Testbench for stream_upsizer_flushable (8-bit beats, Ratio 4): directed
// vectors with hand-computed words plus a short random stress phase. Expected
// words go into a queue; a monitor pops them on each output handshake.
module tb_stream_upsizer_flushable;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  data_i;
   logic        last_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] data_o;
   logic [3:0]  strb_o;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } word_t;

   word_t exp_q[$];

   // Reference model state
   logic       m_state;
   int         m_cnt;
   logic [7:0] m_beats[4];
   logic [3:0] m_strb;

   stream_upsizer_flushable #(
      .T     (logic [7:0]),
      .Ratio (4)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .last_i  (last_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (data_o),
      .strb_o  (strb_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input logic [3:0] s);
      logic [31:0] m;
      for (int k = 0; k < 4; k++) m[8*k +: 8] = s[k] ? 8'hFF : 8'h00;
      return m;
   endfunction

   // Monitor: every output handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_ni && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", {28'd0, strb_o}, 32'hFFFF_FFFF);
         end else begin
            word_t w;
            w = exp_q.pop_front();
            check("word_strb", {28'd0, strb_o}, {28'd0, w.strb});
            check("word_data", data_o & mask_of(w.strb), w.data);
         end
      end
   end

   task automatic model_reset();
      m_state = 1'b0;
      m_cnt   = 0;
      m_strb  = '0;
      exp_q.delete();
   endtask

   // One clock cycle: drive inputs after the edge, check handshake outputs
   // against the model at the falling edge, then advance the model.
   task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                      input logic r, input logic f);
      logic       e_ready, e_valid, hin, hout;
      logic [31:0] wd;
      @(posedge clk);
      #1;
      valid_i = v; data_i = d; last_i = l; ready_i = r; flush_i = f;
      @(negedge clk);
      e_ready = f ? 1'b0 : (m_state ? r : 1'b1);
      e_valid = f ? 1'b0 : m_state;
      check("ready_o", {31'd0, ready_o}, {31'd0, e_ready});
      check("valid_o", {31'd0, valid_o}, {31'd0, e_valid});
      hin  = v && e_ready;
      hout = e_valid && r;
      if (f) begin
         if (m_state) void'(exp_q.pop_back());
         m_state = 1'b0;
         m_cnt   = 0;
         m_strb  = '0;
      end else begin
         if (hout) begin
            m_strb  = '0;
            m_state = 1'b0;
         end
         if (hin) begin
            m_beats[m_cnt] = d;
            m_strb[m_cnt]  = 1'b1;
            if (m_cnt == 3 || l) begin
               for (int k = 0; k < 4; k++) wd[8*k +: 8] = m_beats[k];
               exp_q.push_back('{data: wd & mask_of(m_strb), strb: m_strb});
               m_cnt   = 0;
               m_state = 1'b1;
            end else begin
               m_cnt++;
            end
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; last_i = 1'b0;
      ready_i = 1'b0; data_i = '0;
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; data_i = '0;
      last_i = 1'b0; ready_i = 1'b0;
      model_reset();
      do_reset();
      check("rst_valid_o", {31'd0, valid_o}, 32'd0);
      check("rst_ready_o", {31'd0, ready_o}, 32'd1);
      check("rst_strb_o", {28'd0, strb_o}, 32'd0);
      check("rst_data_o", data_o, 32'd0);

      // Full word back-to-back
      cyc(1, 8'h11, 0, 1, 0);
      cyc(1, 8'h22, 0, 1, 0);
      cyc(1, 8'h33, 0, 1, 0);
      cyc(1, 8'h44, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      check("full_data", data_o, 32'h4433_2211);
      check("full_strb", {28'd0, strb_o}, 32'hF);
      cyc(0, 8'h00, 0, 1, 0);

      // Early termination via last_i
      cyc(1, 8'hA0, 0, 1, 0);
      cyc(1, 8'hA1, 1, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      check("last_strb", {28'd0, strb_o}, 32'h3);
      check("last_data_lo", {16'd0, data_o[15:0]}, 32'h0000_A1A0);
      cyc(1, 8'hB0, 0, 1, 0);
      cyc(1, 8'hB1, 0, 1, 0);
      cyc(1, 8'hB2, 0, 1, 0);
      cyc(1, 8'hB3, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      check("after_last_data", data_o, 32'hB3B2_B1B0);

      // Back-pressure with a pending beat, then same-cycle refill
      cyc(1, 8'hC0, 0, 0, 0);
      cyc(1, 8'hC1, 0, 0, 0);
      cyc(1, 8'hC2, 0, 0, 0);
      cyc(1, 8'hC3, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'h55, 0, 0, 0);
         check("stall_data", data_o, 32'hC3C2_C1C0);
         check("stall_strb", {28'd0, strb_o}, 32'hF);
      end
      cyc(1, 8'h55, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      check("refill_strb", {28'd0, strb_o}, 32'h1);
      check("refill_data", {24'd0, data_o[7:0]}, 32'h55);
      cyc(1, 8'h66, 0, 1, 0);
      cyc(1, 8'h77, 0, 1, 0);
      cyc(1, 8'h88, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      check("refill_word", data_o, 32'h8877_6655);

      // Flush while collecting drops the partial word and the flush beat
      cyc(1, 8'hD0, 0, 1, 0);
      cyc(1, 8'hD1, 0, 1, 0);
      cyc(1, 8'hDD, 0, 1, 1);
      cyc(0, 8'h00, 0, 1, 0);
      check("flush_strb", {28'd0, strb_o}, 32'h0);
      cyc(1, 8'hE0, 0, 1, 0);
      cyc(1, 8'hE1, 0, 1, 0);
      cyc(1, 8'hE2, 0, 1, 0);
      cyc(1, 8'hE3, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      check("post_flush_word", data_o, 32'hE3E2_E1E0);
      check("post_flush_strb", {28'd0, strb_o}, 32'hF);

      // Flush while holding a completed word: nothing is emitted
      cyc(1, 8'hF0, 0, 0, 0);
      cyc(1, 8'hF1, 0, 0, 0);
      cyc(1, 8'hF2, 0, 0, 0);
      cyc(1, 8'hF3, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 1);
      cyc(0, 8'h00, 0, 1, 0);
      cyc(0, 8'h00, 0, 1, 0);
      check("flush_out_strb", {28'd0, strb_o}, 32'h0);

      // Reset mid-word
      cyc(1, 8'h91, 0, 1, 0);
      cyc(1, 8'h92, 0, 1, 0);
      cyc(1, 8'h93, 0, 1, 0);
      do_reset();
      check("midrst_strb", {28'd0, strb_o}, 32'h0);
      check("midrst_data", data_o, 32'h0);
      check("midrst_ready", {31'd0, ready_o}, 32'd1);
      check("midrst_valid", {31'd0, valid_o}, 32'd0);

      // Random stall / flush / last stress
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 3) != 0), 8'($urandom()),
             1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 15) == 0));
      end
      for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1, 0);
      check("queue_drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
